// File: rtl/task_ctrl_multi.sv
// Task control block for one task shared by N_NODES execution nodes: per-node state and priority,
// a shared execution budget, a per-node starvation watchdog, and per-node sorter bytes.
module task_ctrl_multi #(
    parameter int          N_NODES  = 2,
    parameter logic [3:0]  TASK_ID  = 4'h3,
    parameter int          HIT_W    = 8,
    parameter int          HIT_INIT = 128,
    parameter int          TIMEOUT  = 10000,
    parameter int          AGING    = 1
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [16*N_NODES-1:0]  in_op,
    input  logic [N_NODES-1:0]     in_op_vld,
    output logic [8*N_NODES-1:0]   out_sorter,
    output logic [2*N_NODES-1:0]   out_state,
    output logic [N_NODES-1:0]     exe_grant,
    output logic [N_NODES-1:0]     exe_deny,
    output logic [N_NODES-1:0]     timeout,
    output logic [HIT_W-1:0]       exe_hit
);

    localparam logic [1:0] ST_READY = 2'b00;
    localparam logic [1:0] ST_SUSP  = 2'b01;
    localparam logic [1:0] ST_WAIT  = 2'b10;
    localparam logic [1:0] ST_TERM  = 2'b11;

    localparam logic [3:0] OP_READY   = 4'h1;
    localparam logic [3:0] OP_SUSPEND = 4'h2;
    localparam logic [3:0] OP_WAIT    = 4'h3;
    localparam logic [3:0] OP_KILL    = 4'h4;
    localparam logic [3:0] OP_SETPRIO = 4'h5;
    localparam logic [3:0] OP_SETHIT  = 4'h6;
    localparam logic [3:0] OP_EXECUTE = 4'h7;
    localparam logic [3:0] OP_INCPRIO = 4'h8;
    localparam logic [3:0] OP_KILLALL = 4'hC;

    localparam int         WD_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [1:0]       r_state [N_NODES];
    logic [3:0]       r_prio  [N_NODES];
    logic [WD_W-1:0]  r_wd    [N_NODES];
    logic [HIT_W-1:0] r_exe_hit;
    logic [N_NODES-1:0] r_grant;
    logic [N_NODES-1:0] r_deny;
    logic [N_NODES-1:0] r_timeout;

    logic [3:0]         w_opc   [N_NODES];
    logic [3:0]         w_arg   [N_NODES];
    logic [N_NODES-1:0] w_match;
    logic [N_NODES-1:0] w_act;
    logic [N_NODES-1:0] w_exec;
    logic [N_NODES-1:0] w_elig;
    logic [N_NODES-1:0] w_grant;
    logic [N_NODES-1:0] w_deny;
    logic [N_NODES-1:0] w_fire;
    logic               w_kill_all;
    logic               w_sethit_any;
    logic [3:0]         w_sethit_arg;
    logic               w_granted;

    always_comb begin
        w_kill_all   = 1'b0;
        w_sethit_any = 1'b0;
        w_sethit_arg = '0;
        w_granted    = 1'b0;
        w_match      = '0;
        w_act        = '0;
        w_exec       = '0;
        w_elig       = '0;
        w_grant      = '0;
        w_deny       = '0;
        w_fire       = '0;
        for (int unsigned i = 0; i < N_NODES; i++) begin
            w_opc[i]   = in_op[16*i+4 +: 4];
            w_arg[i]   = in_op[16*i   +: 4];
            w_match[i] = in_op_vld[i] && (in_op[16*i+8 +: 4] == TASK_ID);
            // a terminated node's KILL_ALL still counts; everything else it sends is dropped
            w_act[i]   = w_match[i] && (r_state[i] != ST_TERM);
            if (w_match[i] && w_opc[i] == OP_KILLALL)
                w_kill_all = 1'b1;
            if (w_act[i] && w_opc[i] == OP_SETHIT && !w_sethit_any) begin
                w_sethit_any = 1'b1;
                w_sethit_arg = w_arg[i];
            end
            w_exec[i] = w_act[i] && (w_opc[i] == OP_EXECUTE);
            w_elig[i] = w_exec[i] && (r_state[i] == ST_READY) && (r_exe_hit != '0);
        end
        for (int unsigned i = 0; i < N_NODES; i++) begin
            if (w_elig[i] && !w_granted && !w_kill_all && !w_sethit_any) begin
                w_grant[i] = 1'b1;
                w_granted  = 1'b1;
            end
            w_deny[i] = w_exec[i] && !w_grant[i];
            w_fire[i] = (r_state[i] == ST_READY) && (r_wd[i] == WD_LAST) && !w_grant[i];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_exe_hit <= HIT_W'(HIT_INIT);
            r_grant   <= '0;
            r_deny    <= '0;
            r_timeout <= '0;
            for (int unsigned i = 0; i < N_NODES; i++) begin
                r_state[i] <= ST_READY;
                r_prio[i]  <= '0;
                r_wd[i]    <= '0;
            end
        end else begin
            r_grant   <= w_grant;
            r_deny    <= w_deny;
            r_timeout <= w_fire;
            if (!w_kill_all && w_sethit_any)
                r_exe_hit <= HIT_W'(w_sethit_arg);
            else if (w_granted)
                r_exe_hit <= r_exe_hit - 1'b1;

            for (int unsigned i = 0; i < N_NODES; i++) begin
                if (w_kill_all) begin
                    r_state[i] <= ST_TERM;
                end else if (w_act[i]) begin
                    case (w_opc[i])
                        OP_READY:   r_state[i] <= ST_READY;
                        OP_SUSPEND: r_state[i] <= ST_SUSP;
                        OP_WAIT:    r_state[i] <= ST_WAIT;
                        OP_KILL:    r_state[i] <= ST_TERM;
                        default:    r_state[i] <= r_state[i];
                    endcase
                end

                // explicit priority ops win over aging in the same cycle
                if (!w_kill_all && w_act[i] && w_opc[i] == OP_SETPRIO)
                    r_prio[i] <= w_arg[i];
                else if (!w_kill_all && w_act[i] && w_opc[i] == OP_INCPRIO) begin
                    if (r_prio[i] != 4'hF)
                        r_prio[i] <= r_prio[i] + 1'b1;
                end else if (AGING != 0 && w_fire[i] && r_prio[i] != 4'hF)
                    r_prio[i] <= r_prio[i] + 1'b1;

                if (r_state[i] != ST_READY || w_grant[i] || r_wd[i] == WD_LAST)
                    r_wd[i] <= '0;
                else
                    r_wd[i] <= r_wd[i] + 1'b1;
            end
        end
    end

    always_comb begin
        out_sorter = '0;
        out_state  = '0;
        for (int unsigned i = 0; i < N_NODES; i++) begin
            out_state[2*i +: 2] = r_state[i];
            if (r_state[i] == ST_READY)
                out_sorter[8*i +: 8] = {r_prio[i], TASK_ID};
        end
    end

    assign exe_grant = r_grant;
    assign exe_deny  = r_deny;
    assign timeout   = r_timeout;
    assign exe_hit   = r_exe_hit;

endmodule

// File: tb/tb_task_ctrl_multi.sv
// Directed bench for task_ctrl_multi (N_NODES=2, TASK_ID=3, TIMEOUT=16, AGING=1).
module tb_task_ctrl_multi;

    logic        CLK;
    logic        RST_N;
    logic [31:0] in_op;
    logic [1:0]  in_op_vld;
    logic [15:0] out_sorter;
    logic [3:0]  out_state;
    logic [1:0]  exe_grant;
    logic [1:0]  exe_deny;
    logic [1:0]  timeout;
    logic [7:0]  exe_hit;

    int checks = 0;
    int errors = 0;

    task_ctrl_multi #(
        .N_NODES(2), .TASK_ID(4'h3), .HIT_W(8), .HIT_INIT(128), .TIMEOUT(16), .AGING(1)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .in_op(in_op), .in_op_vld(in_op_vld),
        .out_sorter(out_sorter), .out_state(out_state), .exe_grant(exe_grant),
        .exe_deny(exe_deny), .timeout(timeout), .exe_hit(exe_hit)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive one cycle of ops, sample 1 time unit after the edge, then drop valids
    task automatic step(input logic [15:0] op0, input logic v0, input logic [15:0] op1, input logic v1);
        @(negedge CLK);
        in_op     = {op1, op0};
        in_op_vld = {v1, v0};
        @(posedge CLK);
        #1;
        in_op_vld = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        RST_N     = 1'b0;
        in_op     = '0;
        in_op_vld = '0;
        #12;
        chk("rst_sorter",  out_sorter, 16'h0303);
        chk("rst_hit",     exe_hit,    8'd128);
        chk("rst_state",   out_state,  4'b0000);
        chk("rst_pulses",  {exe_grant, exe_deny, timeout}, 6'b0);
        @(negedge CLK);
        RST_N = 1'b1;

        step(16'h0359, 1, 16'h0000, 0);
        chk("setprio_sorter", out_sorter[7:0], 8'h93);
        step(16'h0320, 1, 16'h0000, 0);
        chk("suspend_sorter", out_sorter[7:0], 8'h00);
        chk("suspend_state",  out_state, 4'b0001);
        step(16'h0310, 1, 16'h0000, 0);
        chk("ready_sorter",   out_sorter[7:0], 8'h93);

        step(16'h0370, 1, 16'h0370, 1);
        chk("exec2_grant", exe_grant, 2'b01);
        chk("exec2_deny",  exe_deny,  2'b10);
        chk("exec2_hit",   exe_hit,   8'd127);
        step(16'h0360, 1, 16'h0000, 0);
        chk("sethit0_hit", exe_hit, 8'd0);
        step(16'h0370, 1, 16'h0370, 1);
        chk("exec0_deny",  exe_deny,  2'b11);
        chk("exec0_grant", exe_grant, 2'b00);
        chk("exec0_hit",   exe_hit,   8'd0);

        step(16'h0365, 1, 16'h0370, 1);
        chk("sethit_hit",   exe_hit,   8'd5);
        chk("sethit_deny",  exe_deny,  2'b10);
        chk("sethit_grant", exe_grant, 2'b00);
        step(16'h0470, 1, 16'h0000, 0);
        chk("wrongid_pulses", {exe_grant, exe_deny}, 4'b0000);
        chk("wrongid_hit",    exe_hit, 8'd5);
        step(16'h0370, 1, 16'h0000, 0);
        chk("exec1_grant", exe_grant, 2'b01);
        chk("exec1_hit",   exe_hit,   8'd4);

        step(16'h0000, 0, 16'h0330, 1);
        chk("wait_state",  out_state, 4'b1000);
        chk("wait_sorter", out_sorter[15:8], 8'h00);
        step(16'h0000, 0, 16'h0370, 1);
        chk("notready_deny", exe_deny, 2'b10);
        chk("notready_hit",  exe_hit,  8'd4);

        step(16'h0380, 1, 16'h0000, 0);
        chk("incprio", out_sorter[7:0], 8'hA3);
        step(16'h035F, 1, 16'h0000, 0);
        step(16'h0380, 1, 16'h0000, 0);
        chk("incprio_sat", out_sorter[7:0], 8'hF3);

        step(16'h0000, 0, 16'h03C0, 1);
        chk("killall_state",  out_state,  4'b1111);
        chk("killall_sorter", out_sorter, 16'h0000);
        step(16'h0310, 1, 16'h0000, 0);
        chk("term_ready_state", out_state, 4'b1111);
        step(16'h0370, 1, 16'h0000, 0);
        chk("term_exec_pulses", {exe_grant, exe_deny}, 4'b0000);
        step(16'h0365, 1, 16'h0000, 0);
        chk("term_sethit_hit", exe_hit, 8'd4);

        do_reset();
        chk("rerst_state", out_state, 4'b0000);
        for (int k = 1; k <= 272; k++) begin
            @(posedge CLK);
            #1;
            chk("wd_pulse", timeout, (k % 16 == 0) ? 2'b11 : 2'b00);
            if (k % 16 == 0)
                chk("wd_aging", out_sorter[7:0], {((k / 16) > 15) ? 4'hF : 4'(k / 16), 4'h3});
        end

        do_reset();
        repeat (15) @(posedge CLK);
        step(16'h0370, 1, 16'h0000, 0);
        chk("wd_grant_grant",   exe_grant, 2'b01);
        chk("wd_grant_timeout", timeout,   2'b10);
        chk("wd_grant_sorter",  out_sorter, 16'h1303);
        for (int j = 1; j <= 16; j++) begin
            @(posedge CLK);
            #1;
            chk("wd_restart", timeout[0], (j == 16) ? 1'b1 : 1'b0);
        end

        step(16'h0370, 1, 16'h0000, 0);
        chk("pre_rst_grant", exe_grant, 2'b01);
        chk("pre_rst_hit",   exe_hit,   8'd126);
        #1;
        RST_N = 1'b0;
        #1;
        chk("async_rst_grant",  exe_grant,  2'b00);
        chk("async_rst_hit",    exe_hit,    8'd128);
        chk("async_rst_sorter", out_sorter, 16'h0303);
        @(negedge CLK);
        RST_N = 1'b1;
        step(16'h0359, 1, 16'h0000, 0);
        chk("post_rst_op", out_sorter[7:0], 8'h93);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
